// File: rtl/matrix_pkg.sv
// Shared types and sizing for the matrix transpose switch (row loader and transpose stage).
// Element, row and matrix typedefs are packed so whole rows/matrices move as single vectors.
package matrix_pkg;

    localparam int DATA_W    = 8;
    localparam int ROWS      = 4;
    localparam int COLS      = 4;
    localparam int ROW_IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef logic [DATA_W-1:0] elem_t;
    typedef elem_t [COLS-1:0]  row_t;
    typedef row_t  [ROWS-1:0]  matrix_t;

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } bank_e;

endpackage

// File: rtl/mat_bank.sv
// One ROWS x COLS register bank of the ping-pong buffer.
// The ctrl bit is captured together with row 0 so it travels with the matrix.
module mat_bank
    import matrix_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en_i,
    input  logic [ROW_IDX_W-1:0] wr_row_i,
    input  row_t                 row_data_i,
    input  logic                 ctrl_i,
    output matrix_t              data_o,
    output logic                 ctrl_o
);

    matrix_t data_q;
    logic    ctrl_q;

    // Contents are cleared on reset so the read side shows zeros until a matrix lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            ctrl_q <= 1'b0;
        end else if (wr_en_i) begin
            data_q[wr_row_i] <= row_data_i;
            if (wr_row_i == '0) begin
                ctrl_q <= ctrl_i;
            end
        end
    end

    assign data_o = data_q;
    assign ctrl_o = ctrl_q;

endmodule

// File: rtl/matrix_row_loader.sv
// Assembles row-serial input into complete matrices using a two-bank ping-pong buffer,
// so one matrix can fill while the other waits for the transpose stage.
module matrix_row_loader
    import matrix_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  row_t                 row_in,
    input  logic                 row_val,
    output logic                 row_rdy,
    input  logic                 ctrl_in,
    input  logic                 clr,
    output matrix_t              matrix_out,
    output logic                 ctrl_out,
    output logic                 mat_val,
    input  logic                 mat_rdy,
    output logic [ROW_IDX_W-1:0] row_idx
);

    logic                 init_q;
    bank_e                wr_bank_q, wr_bank_d;
    bank_e                rd_bank_q, rd_bank_d;
    logic [1:0]           full_q, full_d;
    logic [ROW_IDX_W-1:0] row_cnt_q, row_cnt_d;

    logic    row_accept;
    logic    last_row;
    logic    mat_accept;
    logic    bank_wr_en [2];
    matrix_t bank_data  [2];
    logic    bank_ctrl  [2];

    // init_q holds row_rdy low until the first edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_q    <= 1'b0;
            wr_bank_q <= BANK0;
            rd_bank_q <= BANK0;
            full_q    <= 2'b00;
            row_cnt_q <= '0;
        end else begin
            init_q    <= 1'b1;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    always_comb begin
        row_accept = row_val && row_rdy && !clr;
        last_row   = row_accept && (row_cnt_q == ROW_IDX_W'(ROWS - 1));
        mat_accept = mat_val && mat_rdy;

        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        row_cnt_d = row_cnt_q;

        if (clr || last_row) begin
            row_cnt_d = '0;
        end else if (row_accept) begin
            row_cnt_d = row_cnt_q + 1'b1;
        end

        // A drain and a fill can coincide; they always target different banks.
        if (mat_accept) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = (rd_bank_q == BANK0) ? BANK1 : BANK0;
        end
        if (last_row) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = (wr_bank_q == BANK0) ? BANK1 : BANK0;
        end

        bank_wr_en[0] = row_accept && (wr_bank_q == BANK0);
        bank_wr_en[1] = row_accept && (wr_bank_q == BANK1);
    end

    mat_bank u_bank0 (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (bank_wr_en[0]),
        .wr_row_i   (row_cnt_q),
        .row_data_i (row_in),
        .ctrl_i     (ctrl_in),
        .data_o     (bank_data[0]),
        .ctrl_o     (bank_ctrl[0])
    );

    mat_bank u_bank1 (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (bank_wr_en[1]),
        .wr_row_i   (row_cnt_q),
        .row_data_i (row_in),
        .ctrl_i     (ctrl_in),
        .data_o     (bank_data[1]),
        .ctrl_o     (bank_ctrl[1])
    );

    assign row_rdy    = init_q && !full_q[wr_bank_q];
    assign mat_val    = full_q[rd_bank_q];
    assign matrix_out = bank_data[rd_bank_q];
    assign ctrl_out   = bank_ctrl[rd_bank_q];
    assign row_idx    = row_cnt_q;

endmodule
